// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter fed by a first-word-fall-through FIFO.
// Frame format (data bits, parity, stop bits) is captured per frame at pop time.
//   clk, rst_n        - clock, async active-low reset
//   baud_divisor      - clk cycles per bit (0 behaves as 1)
//   i_data_bits       - data bits per frame, clamped to 5..DATA_W
//   i_parity_type     - 00 none, 01 even, 10 mark, 11 odd
//   i_stop2           - 1 selects two stop bits
//   i_en              - allows new frames to start
//   tx_data           - FIFO head word
//   i_fifo_empty      - FIFO empty flag
//   o_fifo_rd_en      - one-cycle pop strobe
//   tx                - serial line, idle high
//   o_busy            - high whenever not idle
//   o_frame_done      - one-cycle pulse after the last stop bit
//   baud_tick_o       - bit-period tick from the baud counter
module uart_tx_cfg #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_divisor,
    input  logic [3:0]        i_data_bits,
    input  logic [1:0]        i_parity_type,
    input  logic              i_stop2,
    input  logic              i_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    output logic              tx,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              baud_tick_o
);

    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BIT_W-1:0]    nbits_q, nbits_d;
    logic [1:0]          par_q, par_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                rd_q, rd_d;
    logic                done_q, done_d;

    logic [DIV_W-1:0]    div_eff_c;
    logic                tick_c;
    logic                start_ok_c;
    logic                capture_c;
    logic [BIT_W-1:0]    nbits_clamp_c;
    logic                par_x_c;
    logic                par_bit_c;
    logic [DATA_W-1:0]   data_sh_c;

    // Baud timing: a zero divisor behaves as one cycle per bit.
    assign div_eff_c  = (baud_divisor == '0) ? DIV_W'(1) : baud_divisor;
    assign tick_c     = (cnt_q == (div_eff_c - DIV_W'(1)));
    assign start_ok_c = i_en && !i_fifo_empty;

    // Data-bit clamp to the legal 5..DATA_W range.
    always_comb begin
        nbits_clamp_c = i_data_bits;
        if (i_data_bits < BIT_W'(5)) begin
            nbits_clamp_c = BIT_W'(5);
        end else if (32'(i_data_bits) > DATA_W) begin
            nbits_clamp_c = BIT_W'(DATA_W);
        end
    end

    // Next-state, shadow capture and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick_c ? '0 : cnt_q + DIV_W'(1);
        bit_d     = bit_q;
        data_d    = data_q;
        nbits_d   = nbits_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        rd_d      = 1'b0;
        done_d    = 1'b0;
        capture_c = 1'b0;
        par_x_c   = 1'b0;
        par_bit_c = 1'b0;
        data_sh_c = '0;
        tx_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_ok_c) begin
                    capture_c = 1'b1;
                end
            end
            S_START: begin
                if (tick_c) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    if (bit_q == (nbits_q - BIT_W'(1))) begin
                        bit_d   = '0;
                        state_d = (par_q == 2'b00) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick_c) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    if (bit_q == {{(BIT_W-1){1'b0}}, stop2_q}) begin
                        done_d = 1'b1;
                        if (start_ok_c) begin
                            capture_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pop and latch the frame configuration; the counter restarts so the
        // start bit lasts a full bit period.
        if (capture_c) begin
            state_d = S_START;
            rd_d    = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            data_d  = tx_data;
            nbits_d = nbits_clamp_c;
            par_d   = i_parity_type;
            stop2_d = i_stop2;
        end

        // Parity covers only the bits actually sent.
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < 32'(nbits_d)) begin
                par_x_c = par_x_c ^ data_d[i];
            end
        end
        case (par_d)
            2'b10:   par_bit_c = 1'b1;
            2'b11:   par_bit_c = ~par_x_c;
            default: par_bit_c = par_x_c;
        endcase

        // tx is computed from the next state so the register lines up with it.
        data_sh_c = data_d >> bit_d;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_sh_c[0];
            S_PARITY: tx_d = par_bit_c;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            nbits_q <= '0;
            par_q   <= '0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
            par_q   <= par_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign o_fifo_rd_en = rd_q;
    assign o_frame_done = done_q;
    assign o_busy       = (state_q != S_IDLE);
    assign baud_tick_o  = tick_c;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 9, giving the maximum data bits per frame (legal 5..9).
REQ-002 The block SHALL have the parameter DIV_W, default 16, giving the width of the baud divisor.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port baud_divisor, input, DIV_W bits: clk cycles per bit; 0 treated as 1.
REQ-006 The block SHALL have the port i_data_bits, input, 4 bits: data bits per frame; values below 5 clamp to 5, values above DATA_W clamp to DATA_W.
REQ-007 The block SHALL have the port i_parity_type, input, 2 bits: 00 none, 01 even, 10 mark (always 1), 11 odd.
REQ-008 The block SHALL have the port i_stop2, input, 1 bit: 0 gives one stop bit, 1 gives two stop bits.
REQ-009 The block SHALL have the port i_en, input, 1 bit: when low, no new frame starts; a frame already in progress completes.
REQ-010 The block SHALL have the port tx_data, input, DATA_W bits: the FIFO head word, first-word-fall-through, valid while i_fifo_empty is low.
REQ-011 The block SHALL have the port i_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-012 The block SHALL have the port o_fifo_rd_en, output, 1 bit: one-cycle pop strobe.
REQ-013 The block SHALL have the port tx, output, 1 bit: registered serial line, idle high.
REQ-014 The block SHALL have the port o_busy, output, 1 bit: high in every state other than IDLE.
REQ-015 The block SHALL have the port o_frame_done, output, 1 bit: one-cycle pulse at the end of the final stop bit.
REQ-016 The block SHALL have the port baud_tick_o, output, 1 bit: the internal bit-period tick.

Function
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-018 In IDLE, when i_en=1 and i_fifo_empty=0, the block SHALL, in the same cycle, pulse o_fifo_rd_en; capture tx_data, the clamped i_data_bits, i_parity_type and i_stop2 into shadow registers; clear the baud counter; and go to START.
REQ-019 Configuration inputs SHALL be sampled only at that capture point; changes mid-frame SHALL have no effect on the frame in progress.
REQ-020 The baud counter SHALL run from 0 to (divisor-1); baud_tick SHALL be high when the count equals divisor-1, and the counter SHALL then wrap to 0.
REQ-021 The baud counter SHALL be held at 0 in IDLE, so every bit, including the start bit, lasts exactly divisor cycles.
REQ-022 In START, tx SHALL be 0; on baud_tick the FSM SHALL go to DATA.
REQ-023 In DATA, tx SHALL carry the shadow data LSB first, advancing one bit per baud_tick; after N ticks the FSM SHALL go to PARITY if parity is not none, otherwise to STOP.
REQ-024 The parity bit SHALL be computed over the N transmitted bits only: even = XOR of those bits, odd = inverted XOR, mark = 1.
REQ-025 In PARITY, tx SHALL be the parity bit for one bit period.
REQ-026 In STOP, tx SHALL be 1 for one or two bit periods, according to the shadowed i_stop2.
REQ-027 On the final STOP baud_tick, o_frame_done SHALL pulse for one cycle.
REQ-028 On the final STOP baud_tick, if i_en=1 and i_fifo_empty=0, the block SHALL pop and capture as in REQ-018 and go directly to START, leaving no idle gap between frames; otherwise it SHALL go to IDLE.
REQ-029 The frame length SHALL be divisor×(1+N+P+S) cycles, where P is 0 or 1 and S is 1 or 2.
REQ-030 o_fifo_rd_en SHALL never be asserted while i_fifo_empty=1, and SHALL assert at most once per frame.
REQ-031 tx, o_fifo_rd_en and o_frame_done SHALL be registered outputs.
REQ-032 o_busy SHALL follow the registered state.
REQ-033 baud_tick_o SHALL be combinational from the counter.

Reset
REQ-034 While rst_n=0, the block SHALL force: tx=1, o_fifo_rd_en=0, o_busy=0, o_frame_done=0, baud counter=0, bit counter=0, shadow registers=0, state=IDLE.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, driving tx high without completing the stop bit.
REQ-036 After release, the first frame SHALL start only under the REQ-018 conditions.

Verification
REQ-037 Basic 8N1: divisor=4, 8N1, tx_data=0xA5 -> one rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame is 40 cycles; o_frame_done pulses once.
REQ-038 Even parity: divisor=2, data_bits=7, even parity, two stop bits, data 0x55 -> bits 1,0,1,0,1,0,1 then parity 0, then stop,stop; frame is 22 cycles.
REQ-039 Back-to-back: FIFO holds 0x01 and 0x80, 8N1, divisor=3 -> two rd_en pulses 30 cycles apart; the second start bit follows the first stop bit with no idle cycle.
REQ-040 Clamp and divisor: data_bits=3, odd parity, divisor=0 -> 5 data bits, parity = inverted XOR of the 5 bits, every bit lasts 1 cycle.
REQ-041 Reset mid-frame: assert rst_n=0 during DATA -> tx=1 within the same cycle; o_busy=0; no rd_en after release while i_fifo_empty=1.
REQ-042 Enable and config timing: i_en=0 with FIFO non-empty -> no rd_en and tx stays 1; raise i_en -> frame starts; change parity mid-frame -> current frame unchanged.
